// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic constants and the modular-subtract correction helper.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ntt_pkg;

  localparam int unsigned NTT_K_DEF = 8;
  localparam int unsigned NTT_N_DEF = 256;
  localparam int unsigned NTT_EXT_W = NTT_K_DEF + 1;
  // Widest operand the helper supports; callers sign-extend D and truncate the result.
  localparam int unsigned NTT_KMAX  = 64;

  // One conditional +M when the extended difference is negative; no second reduction.
  function automatic logic [NTT_KMAX-1:0] mod_sub_correct(input logic [NTT_KMAX:0]   d,
                                                          input logic [NTT_KMAX-1:0] m);
    return d[NTT_KMAX] ? (d[NTT_KMAX-1:0] + m) : d[NTT_KMAX-1:0];
  endfunction

endpackage

// File: rtl/ntt_frame_counter.sv
// Frame position counter: counts accepted outputs modulo N, flags the last slot.
// Latency: count updates the cycle after an advance pulse.
// Backpressure: none; only moves when the caller signals a completed handshake.
module ntt_frame_counter
  import ntt_pkg::*;
#(
  parameter int N = NTT_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 advance,
  output logic [$clog2(N)-1:0] count,
  output logic                 last
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance) begin
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign last  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/ntt_mod_sub_pipe.sv
// Streaming C = (A - B) mod M with frame-end marking; NTT_MOD_SUB_RANGE_CHECK_EN adds sticky err.
// Latency: 2 cycles from input handshake to out_valid, one result per cycle.
// Backpressure: two-entry skid (S1, S2); in_ready drops only when both are full and stalled.
module ntt_mod_sub_pipe
  import ntt_pkg::*;
#(
  parameter int K = NTT_K_DEF,
  parameter int N = NTT_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] in_a,
  input  logic [K-1:0] in_b,
  input  logic [K-1:0] in_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_c,
  output logic         out_last
`ifdef NTT_MOD_SUB_RANGE_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int CW = $clog2(N);

  logic         s1_valid_q, s1_valid_d;
  logic [K-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic         s2_valid_q, s2_valid_d;
  logic [K-1:0] c_q, c_d;
  logic [K:0]   diff;
  logic         s2_load, in_fire, out_fire;
  logic [CW-1:0] frame_cnt_unused;
  logic         frame_last;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;
  assign diff     = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    s2_valid_d = s2_valid_q;
    c_d        = c_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      s1_valid_d = 1'b0;
      if (s1_valid_q) begin
        c_d = K'(mod_sub_correct({{(NTT_KMAX - K){diff[K]}}, diff}, NTT_KMAX'(m_q)));
      end
    end
    // A new triple refills S1 in the same cycle the old one moves on.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      a_d        = in_a;
      b_d        = in_b;
      m_d        = in_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      s2_valid_q <= s2_valid_d;
      c_q        <= c_d;
    end
  end

  ntt_frame_counter #(
    .N(N)
  ) u_frame_counter (
    .clk     (clk),
    .rst     (rst),
    .advance (out_fire),
    .count   (frame_cnt_unused),
    .last    (frame_last)
  );

  assign out_valid = s2_valid_q;
  assign out_c     = c_q;
  assign out_last  = s2_valid_q && frame_last;

`ifdef NTT_MOD_SUB_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (in_fire && ((in_a >= in_m) || (in_b >= in_m))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/ntt_mod_sub_pipe.md
Name: ntt_mod_sub_pipe

Overview:
Streaming pipelined modular subtractor computing C = (A - B) mod M for NTT coefficient data. It is the subtract-side counterpart of the combinational modular adder. It feeds the difference leg of the inverse-NTT (Gentleman-Sande) butterfly datapath. It adds a valid/ready handshake, a fixed 2-cycle pipeline and a frame counter that marks the last coefficient of each N-point block.

Parameters:
K, 8, operand/modulus width in bits
N, 256, coefficients per frame; must be >= 2; counter width CW = $clog2(N)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operand triple valid
in_ready  output  1  block can accept the triple this cycle
in_a  input  K  minuend A, nominally 0 <= A < M
in_b  input  K  subtrahend B, nominally 0 <= B < M
in_m  input  K  modulus M, travels with the operands, nominally M >= 2
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_c  output  K  (A - B) mod M
out_last  output  1  high with the N-th, 2N-th, ... output of a frame

Behaviour:
- One clock, reset synchronous and active-high. Clock port is clk. Reset port is rst.
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_c=0, out_last=0, frame count=0. in_ready=1 from the first cycle after reset.
- Input handshake occurs when in_valid && in_ready. Output handshake occurs when out_valid && out_ready.
- Stage 1 (S1) registers A, B and M.
- S1 -> S2 arithmetic:
  - D = {1'b0,A} - {1'b0,B}, K+1 bits.
  - If D[K]==1 (negative), C = (D + {1'b0,M})[K-1:0]. Otherwise C = D[K-1:0].
  - Single conditional correction only; no second reduction.
- Stage 2 (S2) registers C; out_c is driven directly from the S2 register.
- Latency: a triple accepted in cycle t appears with out_valid=1 in cycle t+2, provided there is no backpressure.
- Throughput: one result per cycle while out_ready=1.
- Stage advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational, no bubbles).
- Backpressure: while out_valid && !out_ready, out_c, out_last and out_valid hold stable. At most 2 triples are held internally.
- Simultaneous input and output handshake in the same cycle: both complete and the pipeline shifts by one.
- Frame counter:
  - Increments on each output handshake and wraps from N-1 to 0.
  - out_last = out_valid && (count == N-1).
  - The counter never advances without an output handshake.
- Out-of-range operands (A >= M or B >= M): the result is the formula above truncated to K bits. It is deterministic but not guaranteed to be reduced.
- Reset mid-operation: all in-flight data is discarded and the frame count returns to 0. out_valid=0 in the cycle after rst is sampled high.
- M may change on every triple; each result uses the M captured with its own operands.

Optional Feature:
- Macro: NTT_MOD_SUB_RANGE_CHECK_EN.
- When defined:
  - Adds output port err (1 bit), a sticky flag.
  - err sets in the cycle after an accepted triple with A >= M or B >= M.
  - err is cleared only by rst; reset value 0.
  - Data path is unchanged.
- When undefined: no err port and no comparators.

Decomposition:
- Shared package ntt_pkg:
  - default K and N constants;
  - the K+1-bit extended-difference width constant;
  - a function mod_sub_correct(D, M) returning the corrected K-bit value, shared with the future butterfly.
- One natural sub-module: ntt_frame_counter (parameter N; inputs clk, rst, advance; outputs count, last). It is reusable by the forward-NTT stream blocks.

Test Plan:
- K=8, M=17, out_ready=1. A=9,B=5 -> out_c=4 two cycles after acceptance. A=5,B=9 -> 13. A=0,B=16 -> 1. A=16,B=16 -> 0.
- Back-to-back stream A=i, B=3, i=0..16, M=17 -> outputs 14,15,16,0,1,...,13 on consecutive cycles, no bubbles, in_ready constant 1.
- Backpressure: 4 triples sent with out_ready held 0 for 5 cycles.
  - in_ready drops after 2 are accepted.
  - out_c holds its first value (stable, with out_valid=1).
  - After release, all 4 results appear in order with none lost or duplicated.
- N=4, 10 back-to-back results -> out_last high exactly on outputs 4 and 8. A random out_ready stall must not shift the out_last position.
- rst asserted for 1 cycle with 2 items in flight and frame count=2 -> next cycle out_valid=0, in_ready=1. The next 4 results (N=4) assert out_last on the 4th.
- With NTT_MOD_SUB_RANGE_CHECK_EN: A=20,B=3,M=17 -> err=1 from the next cycle and stays 1 through valid traffic until rst. Without the macro the same stimulus yields out_c=17, with no err port present.
